// File: rtl/native_port_arbiter.sv
// native_port_arbiter
// Shares one native command / write-data / read-data port of the LPDDR4
// controller between NUM_PORTS requesters.
// - Commands are arbitrated round-robin.
// - A write keeps its grant until its single data beat has been accepted.
// - Read returns come back in order. Each one is routed to the port that
//   issued it, using a FIFO of port IDs.
// Optional feature: define NATIVE_ARB_PERF_CNT_EN to add saturating
// per-port accepted-command counters on the grant_cnt output.

module native_port_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_W        = 27,
    parameter int DATA_W        = 128,
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef NATIVE_ARB_PERF_CNT_EN
    output logic [NUM_PORTS*32-1:0]       grant_cnt,
`endif
    input  logic [NUM_PORTS-1:0]          req_cmd_valid,
    output logic [NUM_PORTS-1:0]          req_cmd_ready,
    input  logic [NUM_PORTS-1:0]          req_cmd_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_cmd_addr,
    input  logic [NUM_PORTS-1:0]          req_wdata_valid,
    output logic [NUM_PORTS-1:0]          req_wdata_ready,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata_data,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_wdata_we,
    output logic [NUM_PORTS-1:0]          req_rdata_valid,
    input  logic [NUM_PORTS-1:0]          req_rdata_ready,
    output logic [DATA_W-1:0]             req_rdata_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_we,
    output logic [ADDR_W-1:0]             cmd_addr,
    output logic                          wdata_valid,
    input  logic                          wdata_ready,
    output logic [DATA_W-1:0]             wdata_data,
    output logic [DATA_W/8-1:0]           wdata_we,
    input  logic                          rdata_valid,
    output logic                          rdata_ready,
    input  logic [DATA_W-1:0]             rdata_data
);

    localparam int BE_W = DATA_W / 8;
    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW   = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CW   = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] grant;
    logic [PW-1:0] next_grant;
    logic [PW-1:0] ptr;
    logic [PW-1:0] arb_winner;
    logic [PW-1:0] cand;
    logic          arb_found;

    logic [PW-1:0] fifo_mem [RD_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          block;
    logic          cmd_accept;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(RD_FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr];

    // Read return path.
    // The FIFO head selects which port sees the downstream read beat.
    // Nothing is accepted from downstream while no read is outstanding.
    always_comb begin
        req_rdata_valid = '0;
        rdata_ready     = 1'b0;
        if (!fifo_empty) begin
            req_rdata_valid[head] = rdata_valid;
            rdata_ready           = req_rdata_ready[head];
        end
    end

    assign req_rdata_data = rdata_data;
    assign pop            = rdata_valid & rdata_ready;

    // Read backpressure.
    // A read may only issue while the FIFO has room. A pop in the same cycle
    // frees a slot, so the read can go out in the cycle the slot frees up.
    assign block      = (state == CMD) & ~req_cmd_we[grant] & fifo_full & ~pop;
    assign cmd_accept = (state == CMD) & req_cmd_valid[grant] & cmd_ready & ~block;
    assign push       = cmd_accept & ~req_cmd_we[grant];

    // Round-robin search.
    // Picks the first requesting port after the pointer, wrapping around.
    always_comb begin
        arb_winner = ptr;
        arb_found  = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PW'((int'(ptr) + k) % NUM_PORTS);
            if (!arb_found && req_cmd_valid[cand]) begin
                arb_winner = cand;
                arb_found  = 1'b1;
            end
        end
    end

    // Next state, plus muxing the granted port onto the downstream interface.
    always_comb begin
        next_state      = state;
        next_grant      = grant;
        cmd_valid       = 1'b0;
        cmd_we          = 1'b0;
        cmd_addr        = '0;
        wdata_valid     = 1'b0;
        wdata_data      = '0;
        wdata_we        = '0;
        req_cmd_ready   = '0;
        req_wdata_ready = '0;
        case (state)
            IDLE: begin
                if (|req_cmd_valid) begin
                    next_grant = arb_winner;
                    next_state = CMD;
                end
            end
            CMD: begin
                cmd_valid            = req_cmd_valid[grant] & ~block;
                cmd_we               = req_cmd_we[grant];
                cmd_addr             = req_cmd_addr[grant*ADDR_W +: ADDR_W];
                req_cmd_ready[grant] = cmd_ready & ~block;
                if (cmd_accept) begin
                    next_state = req_cmd_we[grant] ? WDATA : IDLE;
                end
            end
            WDATA: begin
                wdata_valid            = req_wdata_valid[grant];
                wdata_data             = req_wdata_data[grant*DATA_W +: DATA_W];
                wdata_we               = req_wdata_we[grant*BE_W +: BE_W];
                req_wdata_ready[grant] = wdata_ready;
                if (req_wdata_valid[grant] && wdata_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM state, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= PW'(NUM_PORTS - 1);
        end else begin
            state <= next_state;
            grant <= next_grant;
            if (cmd_accept) begin
                ptr <= grant;
            end
        end
    end

    // Return FIFO pointers and occupancy.
    // A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Return FIFO storage.
    // No reset is needed: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= grant;
        end
    end

`ifdef NATIVE_ARB_PERF_CNT_EN
    logic [31:0] perf_cnt [NUM_PORTS];

    // Per-port accepted-command counters. Each counter stops at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rst) begin
                perf_cnt[i] <= '0;
            end else if (cmd_accept && (grant == PW'(i)) && (perf_cnt[i] != 32'hFFFF_FFFF)) begin
                perf_cnt[i] <= perf_cnt[i] + 32'd1;
            end
        end
    end

    // Pack the counters onto the flat output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_cnt[i*32 +: 32] = perf_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_native_port_arbiter.sv
// tb_native_port_arbiter
// Directed testbench for native_port_arbiter with two ports.
// Inputs are driven and outputs are sampled on the falling clock edge.

module tb_native_port_arbiter;

    localparam int NUM_PORTS = 2;
    localparam int ADDR_W    = 27;
    localparam int DATA_W    = 128;
    localparam int BE_W      = DATA_W / 8;
    localparam int DEPTH     = 8;

    logic                          clk = 1'b0;
    logic                          rst;
`ifdef NATIVE_ARB_PERF_CNT_EN
    logic [NUM_PORTS*32-1:0]       grant_cnt;
`endif
    logic [NUM_PORTS-1:0]          req_cmd_valid;
    logic [NUM_PORTS-1:0]          req_cmd_ready;
    logic [NUM_PORTS-1:0]          req_cmd_we;
    logic [NUM_PORTS*ADDR_W-1:0]   req_cmd_addr;
    logic [NUM_PORTS-1:0]          req_wdata_valid;
    logic [NUM_PORTS-1:0]          req_wdata_ready;
    logic [NUM_PORTS*DATA_W-1:0]   req_wdata_data;
    logic [NUM_PORTS*BE_W-1:0]     req_wdata_we;
    logic [NUM_PORTS-1:0]          req_rdata_valid;
    logic [NUM_PORTS-1:0]          req_rdata_ready;
    logic [DATA_W-1:0]             req_rdata_data;
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_we;
    logic [ADDR_W-1:0]             cmd_addr;
    logic                          wdata_valid;
    logic                          wdata_ready;
    logic [DATA_W-1:0]             wdata_data;
    logic [BE_W-1:0]               wdata_we;
    logic                          rdata_valid;
    logic                          rdata_ready;
    logic [DATA_W-1:0]             rdata_data;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [DATA_W-1:0] DATA_A5 = {16{8'hA5}};
    localparam logic [DATA_W-1:0] DATA_3C = {16{8'h3C}};
    localparam logic [DATA_W-1:0] D0      = {4{32'h1111_0000}};
    localparam logic [DATA_W-1:0] D1      = {4{32'h2222_0001}};
    localparam logic [DATA_W-1:0] D2      = {4{32'h3333_0002}};

    native_port_arbiter #(
        .NUM_PORTS    (NUM_PORTS),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .RD_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef NATIVE_ARB_PERF_CNT_EN
        .grant_cnt      (grant_cnt),
`endif
        .req_cmd_valid  (req_cmd_valid),
        .req_cmd_ready  (req_cmd_ready),
        .req_cmd_we     (req_cmd_we),
        .req_cmd_addr   (req_cmd_addr),
        .req_wdata_valid(req_wdata_valid),
        .req_wdata_ready(req_wdata_ready),
        .req_wdata_data (req_wdata_data),
        .req_wdata_we   (req_wdata_we),
        .req_rdata_valid(req_rdata_valid),
        .req_rdata_ready(req_rdata_ready),
        .req_rdata_data (req_rdata_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_we         (cmd_we),
        .cmd_addr       (cmd_addr),
        .wdata_valid    (wdata_valid),
        .wdata_ready    (wdata_ready),
        .wdata_data     (wdata_data),
        .wdata_we       (wdata_we),
        .rdata_valid    (rdata_valid),
        .rdata_ready    (rdata_ready),
        .rdata_data     (rdata_data)
    );

    always #5 clk = ~clk;

    // Hold reset for two edges with every input idle, then release it on a
    // falling edge.
    task automatic do_reset();
        rst             = 1'b1;
        req_cmd_valid   = '0;
        req_cmd_we      = '0;
        req_cmd_addr    = '0;
        req_wdata_valid = '0;
        req_wdata_data  = '0;
        req_wdata_we    = '0;
        req_rdata_ready = '0;
        cmd_ready       = 1'b0;
        wdata_ready     = 1'b0;
        rdata_valid     = 1'b0;
        rdata_data      = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_rdata_ready = 2'b11;
        rdata_valid     = 1'b1;
        cmd_ready       = 1'b1;
        wdata_ready     = 1'b1;
        req_cmd_valid   = 2'b11;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_cmd_valid: got %0b expected 0", cmd_valid);
        end
        n_cmp++;
        if (req_cmd_ready !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL reset_req_cmd_ready: got %b expected 00", req_cmd_ready);
        end
        n_cmp++;
        if (wdata_valid !== 1'b0 || req_wdata_ready !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL reset_wdata: got valid=%0b ready=%b expected 0/00", wdata_valid, req_wdata_ready);
        end
        n_cmp++;
        if (rdata_ready !== 1'b0 || req_rdata_valid !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL reset_rdata: got ready=%0b valid=%b expected 0/00", rdata_ready, req_rdata_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]        exp_rdy;
        logic [ADDR_W-1:0] exp_addr;
        do_reset();
        req_cmd_valid = 2'b11;
        req_cmd_we    = 2'b00;
        req_cmd_addr  = {27'h20, 27'h10};
        cmd_ready     = 1'b1;
        #1;
        n_cmp++;
        if (cmd_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rr_latency: got cmd_valid=%0b expected 0", cmd_valid);
        end
        for (int k = 0; k < 4; k++) begin
            exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 27'h10 : 27'h20;
            @(negedge clk);
            n_cmp++;
            if (cmd_valid !== 1'b1 || req_cmd_ready !== exp_rdy) begin
                n_bad++;
                $display("[TB] FAIL rr_grant%0d: got valid=%0b ready=%b expected 1/%b", k, cmd_valid, req_cmd_ready, exp_rdy);
            end
            n_cmp++;
            if (cmd_addr !== exp_addr) begin
                n_bad++;
                $display("[TB] FAIL rr_addr%0d: got %0h expected %0h", k, cmd_addr, exp_addr);
            end
            @(negedge clk);
            n_cmp++;
            if (cmd_valid !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL rr_idle%0d: got cmd_valid=%0b expected 0", k, cmd_valid);
            end
        end
        req_cmd_valid = 2'b00;
    endtask

    task automatic test_write_lock();
        do_reset();
        req_cmd_valid   = 2'b10;
        req_cmd_we      = 2'b10;
        req_cmd_addr    = {27'h100, 27'h40};
        req_wdata_data  = {DATA_A5, DATA_3C};
        req_wdata_we    = {16'hFFFF, 16'h0F0F};
        req_wdata_valid = 2'b10;
        cmd_ready       = 1'b1;
        wdata_ready     = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_we !== 1'b1 || cmd_addr !== 27'h100 || req_cmd_ready !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL wr_cmd: got v=%0b we=%0b addr=%0h rdy=%b expected 1/1/100/10", cmd_valid, cmd_we, cmd_addr, req_cmd_ready);
        end
        req_cmd_valid[0]   = 1'b1;
        req_wdata_valid[0] = 1'b1;
        @(negedge clk);
        req_cmd_valid[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++;
            if (wdata_valid !== 1'b1 || wdata_data !== DATA_A5 || req_wdata_ready !== 2'b00 || cmd_valid !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL wr_hold%0d: got wv=%0b wd=%0h wrdy=%b cv=%0b expected 1/a5../00/0", k, wdata_valid, wdata_data, req_wdata_ready, cmd_valid);
            end
        end
        wdata_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_wdata_ready !== 2'b10 || wdata_we !== 16'hFFFF || req_cmd_ready !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL wr_beat: got wrdy=%b we=%0h crdy=%b expected 10/ffff/00", req_wdata_ready, wdata_we, req_cmd_ready);
        end
        @(negedge clk);
        wdata_ready     = 1'b0;
        req_wdata_valid = 2'b00;
        #1;
        n_cmp++;
        if (wdata_valid !== 1'b0 || cmd_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL wr_done_idle: got wv=%0b cv=%0b expected 0/0", wdata_valid, cmd_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 27'h40 || req_cmd_ready !== 2'b01 || cmd_we !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL wr_then_p0: got v=%0b addr=%0h rdy=%b we=%0b expected 1/40/01/0", cmd_valid, cmd_addr, req_cmd_ready, cmd_we);
        end
        @(negedge clk);
        req_cmd_valid = 2'b00;
    endtask

    task automatic test_read_return();
        do_reset();
        req_cmd_valid = 2'b11;
        req_cmd_we    = 2'b00;
        req_cmd_addr  = {27'h2, 27'h1};
        cmd_ready     = 1'b1;
        repeat (4) @(negedge clk);
        req_cmd_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        req_cmd_valid   = 2'b00;
        req_rdata_ready = 2'b11;
        rdata_valid     = 1'b1;
        rdata_data      = D0;
        #1;
        n_cmp++;
        if (req_rdata_valid !== 2'b01 || req_rdata_data !== D0 || rdata_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rd_ret0: got v=%b d=%0h rdy=%0b expected 01/D0/1", req_rdata_valid, req_rdata_data, rdata_ready);
        end
        @(negedge clk);
        rdata_data = D1;
        #1;
        n_cmp++;
        if (req_rdata_valid !== 2'b10 || req_rdata_data !== D1 || rdata_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rd_ret1: got v=%b d=%0h rdy=%0b expected 10/D1/1", req_rdata_valid, req_rdata_data, rdata_ready);
        end
        @(negedge clk);
        rdata_data      = D2;
        req_rdata_ready = 2'b10;
        #1;
        n_cmp++;
        if (rdata_ready !== 1'b0 || req_rdata_valid !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL rd_head_stall: got rdy=%0b v=%b expected 0/01", rdata_ready, req_rdata_valid);
        end
        @(negedge clk);
        req_rdata_ready = 2'b11;
        #1;
        n_cmp++;
        if (req_rdata_valid !== 2'b01 || req_rdata_data !== D2 || rdata_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rd_ret2: got v=%b d=%0h rdy=%0b expected 01/D2/1", req_rdata_valid, req_rdata_data, rdata_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (rdata_ready !== 1'b0 || req_rdata_valid !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL rd_empty: got rdy=%0b v=%b expected 0/00", rdata_ready, req_rdata_valid);
        end
        rdata_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        req_cmd_valid = 2'b01;
        req_cmd_we    = 2'b00;
        req_cmd_addr  = {27'h0, 27'h200};
        cmd_ready     = 1'b1;
        repeat (16) @(negedge clk);
        req_cmd_we         = 2'b01;
        req_cmd_addr       = {27'h0, 27'h300};
        req_wdata_valid    = 2'b01;
        req_wdata_data     = {DATA_A5, DATA_3C};
        req_wdata_we       = {16'h0000, 16'hFFFF};
        wdata_ready        = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_we !== 1'b1 || req_cmd_ready !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL full_write_ok: got v=%0b we=%0b rdy=%b expected 1/1/01", cmd_valid, cmd_we, req_cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (wdata_valid !== 1'b1 || wdata_data !== DATA_3C || req_wdata_ready !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL full_write_beat: got v=%0b d=%0h rdy=%b expected 1/3c../01", wdata_valid, wdata_data, req_wdata_ready);
        end
        req_cmd_we   = 2'b00;
        req_cmd_addr = {27'h0, 27'h400};
        @(negedge clk);
        req_wdata_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b0 || req_cmd_ready !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL full_read_block: got v=%0b rdy=%b expected 0/00", cmd_valid, req_cmd_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL full_read_block2: got v=%0b expected 0", cmd_valid);
        end
        req_rdata_ready = 2'b01;
        rdata_valid     = 1'b1;
        rdata_data      = D0;
        #1;
        n_cmp++;
        if (rdata_ready !== 1'b1 || req_rdata_valid !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL full_pop: got rdy=%0b v=%b expected 1/01", rdata_ready, req_rdata_valid);
        end
        n_cmp++;
        if (cmd_valid !== 1'b1 || req_cmd_ready !== 2'b01 || cmd_addr !== 27'h400) begin
            n_bad++;
            $display("[TB] FAIL full_unblock: got v=%0b rdy=%b addr=%0h expected 1/01/400", cmd_valid, req_cmd_ready, cmd_addr);
        end
        @(negedge clk);
        rdata_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b0 || req_cmd_ready !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL full_still_full: got v=%0b rdy=%b expected 0/00", cmd_valid, req_cmd_ready);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        req_cmd_valid = 2'b11;
        req_cmd_we    = 2'b00;
        req_cmd_addr  = {27'h5, 27'h6};
        cmd_ready     = 1'b1;
        repeat (7) @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b1 || req_cmd_ready !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL mid_in_cmd: got v=%0b rdy=%b expected 1/10", cmd_valid, req_cmd_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b0 || req_cmd_ready !== 2'b00 || wdata_valid !== 1'b0 || req_wdata_ready !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL mid_outputs: got cv=%0b crdy=%b wv=%0b wrdy=%b expected all 0", cmd_valid, req_cmd_ready, wdata_valid, req_wdata_ready);
        end
        rst             = 1'b0;
        req_rdata_ready = 2'b11;
        rdata_valid     = 1'b1;
        rdata_data      = D1;
        #1;
        n_cmp++;
        if (rdata_ready !== 1'b0 || req_rdata_valid !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL mid_fifo_empty: got rdy=%0b v=%b expected 0/00", rdata_ready, req_rdata_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (cmd_valid !== 1'b1 || req_cmd_ready !== 2'b01 || cmd_addr !== 27'h6) begin
            n_bad++;
            $display("[TB] FAIL mid_ptr_reset: got v=%0b rdy=%b addr=%0h expected 1/01/6", cmd_valid, req_cmd_ready, cmd_addr);
        end
        @(negedge clk);
        req_cmd_valid = 2'b00;
        rdata_valid   = 1'b0;
    endtask

`ifdef NATIVE_ARB_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        req_cmd_valid = 2'b11;
        req_cmd_we    = 2'b00;
        req_cmd_addr  = {27'h7, 27'h8};
        cmd_ready     = 1'b1;
        repeat (12) @(negedge clk);
        req_cmd_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        req_cmd_valid = 2'b00;
        n_cmp++;
        if (grant_cnt[31:0] !== 32'd5 || grant_cnt[63:32] !== 32'd3) begin
            n_bad++;
            $display("[TB] FAIL perf_counts: got p0=%0d p1=%0d expected 5/3", grant_cnt[31:0], grant_cnt[63:32]);
        end
        dut.perf_cnt[0] = 32'hFFFF_FFFE;
        req_cmd_valid   = 2'b01;
        req_cmd_we      = 2'b01;
        req_wdata_valid = 2'b01;
        wdata_ready     = 1'b1;
        repeat (6) @(negedge clk);
        req_cmd_valid   = 2'b00;
        req_wdata_valid = 2'b00;
        n_cmp++;
        if (grant_cnt[31:0] !== 32'hFFFF_FFFF || grant_cnt[63:32] !== 32'd3) begin
            n_bad++;
            $display("[TB] FAIL perf_saturate: got p0=%0h p1=%0d expected ffffffff/3", grant_cnt[31:0], grant_cnt[63:32]);
        end
    endtask
`endif

    initial begin
        do_reset();
        test_reset();
        test_round_robin();
        test_write_lock();
        test_read_return();
        test_fifo_full();
        test_reset_midop();
`ifdef NATIVE_ARB_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/native_port_arbiter.md
Name: native_port_arbiter

Overview:
- Shares the single native command/write/read interface of the LPDDR4 controller between NUM_PORTS native requesters (e.g. several AXI-to-native front ends).
- Performs round-robin command arbitration and locks the grant through the write-data beat of a write.
- Routes in-order read returns back to the issuing port using a port-ID return FIFO.
- Sits between the AXI-to-native conversion layer and the controller's native port.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_W, 27, native command address width.
- DATA_W, 128, native data width; byte-enable width is DATA_W/8.
- RD_FIFO_DEPTH, 8, outstanding-read tracking depth (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_cmd_valid  in  NUM_PORTS  per-port command valid.
- req_cmd_ready  out  NUM_PORTS  per-port command accept.
- req_cmd_we  in  NUM_PORTS  1=write, 0=read.
- req_cmd_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W].
- req_wdata_valid  in  NUM_PORTS  per-port write data valid.
- req_wdata_ready  out  NUM_PORTS  per-port write data accept.
- req_wdata_data  in  NUM_PORTS*DATA_W  per-port write data.
- req_wdata_we  in  NUM_PORTS*DATA_W/8  per-port byte enables.
- req_rdata_valid  out  NUM_PORTS  per-port read data valid.
- req_rdata_ready  in  NUM_PORTS  per-port read data accept.
- req_rdata_data  out  DATA_W  read data, broadcast to all ports.
- cmd_valid  out  1  downstream command valid.
- cmd_ready  in  1  downstream command accept.
- cmd_we  out  1  downstream write flag.
- cmd_addr  out  ADDR_W  downstream address.
- wdata_valid  out  1  downstream write data valid.
- wdata_ready  in  1  downstream write data accept.
- wdata_data  out  DATA_W  downstream write data.
- wdata_we  out  DATA_W/8  downstream byte enables.
- rdata_valid  in  1  downstream read data valid.
- rdata_ready  out  1  downstream read data accept.
- rdata_data  in  DATA_W  downstream read data.

Behaviour:
- One clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - All valid/ready outputs are 0.
  - State = IDLE.
  - Round-robin pointer = NUM_PORTS-1, so port 0 wins first.
  - Return FIFO is empty.
- Handshake: a transfer occurs when valid&ready are both high on a rising edge. Each command is exactly one data beat.
- FSM, IDLE:
  - If any req_cmd_valid is set, register grant = first requesting port after the pointer (wrapping), then go to CMD.
  - Arbitration latency is 1 cycle.
- FSM, CMD:
  - cmd_valid/cmd_we/cmd_addr are driven from the granted port.
  - req_cmd_ready[grant] = cmd_ready & ~block, where block = (granted cmd is a read) & fifo_full.
  - cmd_valid is also masked by block.
  - On handshake: pointer ← grant.
    - Write → go to WDATA.
    - Read → push grant into the FIFO, go to IDLE.
- FSM, WDATA:
  - wdata_* are driven from the granted port.
  - req_wdata_ready[grant] = wdata_ready.
  - On handshake → go to IDLE.
  - Other ports' wdata is never forwarded; their req_wdata_ready stays 0.
- Requester rule: a requester must hold cmd_valid and its fields stable until accepted.
- Read return:
  - head = FIFO front.
  - req_rdata_valid[head] = rdata_valid & ~empty; all other bits are 0.
  - rdata_ready = req_rdata_ready[head] & ~empty.
  - Pop on the downstream rdata handshake.
  - With the FIFO empty, rdata_ready=0 (stall; never drop data).
- Simultaneous push and pop in the same cycle is allowed, including when the FIFO is full (a pop frees the slot). The count is unchanged.
- Write commands are never blocked by fifo_full.
- Reset mid-operation: the FSM, FIFO and pointer return to reset values immediately. In-flight reads are discarded.
- Idle cost: each grant costs at least 2 cycles (IDLE + CMD). There are no back-to-back grants from CMD.

Optional Feature:
- Macro: NATIVE_ARB_PERF_CNT_EN.
- Defined:
  - Adds output grant_cnt (NUM_PORTS*32).
  - Per-port counter increments on each accepted command from that port.
  - Counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Test Plan:
- Ports 0 and 1 both hold read cmds continuously, cmd_ready=1 → grants alternate 0,1,0,1. cmd_valid first rises 1 cycle after request.
- Port 1 write addr 0x100, data 0xA5…, wdata_ready delayed 3 cycles → port 1 is held in WDATA. Port 0's pending cmd is not granted until the wdata handshake completes.
- Reads issued in order 0,1,0; rdata returns D0,D1,D2 → req_rdata_valid asserts on ports 0,1,0 with matching data.
- Issue 8 reads with no rdata (RD_FIFO_DEPTH=8) → 9th read is blocked (cmd_valid=0), a write is still accepted. One rdata pop unblocks the read in the same cycle.
- Assert rst in CMD with 3 reads outstanding → next cycle all outputs are 0 and the FIFO is empty. An rdata_valid then sees rdata_ready=0.
- NATIVE_ARB_PERF_CNT_EN defined: 5 cmds from port 0 and 3 from port 1 → grant_cnt shows 5 and 3. Preload the counter near max → it saturates at 0xFFFFFFFF.
